uart_packet_packer: RTL and testbench
=====================================

// Module: uart_packet_packer
// PURPOSE
//  Upstream feeder of the UART TX controller: frames ADS sample pairs and ADS/MPR register-read
//  replies into 56-bit left-justified packets on o_UART_DATA_TX / o_UART_DATA_TX_VALID.
//  Buffers samples in a small FIFO so UART latency never stalls the sensor side.
//  Register replies take priority over samples. Counts dropped samples for debug.
// PARAMETERS
//  FIFO_DEPTH   4      sample FIFO entries; must be a power of two, >=2
//  HDR_ADS_DATA 8'hAA  header byte for ADS sample packets
//  HDR_ADS_REG  8'h61  header byte for ADS register reply ('a')
//  HDR_MPR_REG  8'h6D  header byte for MPR register reply ('m')
// PORTS
//  i_CLK                in   1   system clock
//  i_RSTN               in   1   reset, asynchronous, active-low
//  i_ADS_DATA           in   48  {ch1[23:0], ch2[23:0]} sample pair
//  i_ADS_DATA_VALID     in   1   1-cycle strobe, push sample
//  i_REG_ADDR           in   8   register address of reply
//  i_REG_DATA           in   8   register contents
//  i_REG_SRC            in   1   0 = ADS, 1 = MPR
//  i_REG_VALID          in   1   1-cycle strobe, reply available
//  i_FLUSH              in   1   1-cycle strobe (STOP received): discard FIFO contents
//  i_UART_DATA_TX_READY in   1   controller ready
//  o_UART_DATA_TX       out  56  packet, header in [55:48]
//  o_UART_DATA_TX_VALID out  1   packet valid
//  o_FIFO_FULL          out  1   FIFO holds FIFO_DEPTH entries
//  o_DROP_CNT           out  8   dropped-sample count, saturating
// BEHAVIOUR
//  Reset (async, i_RSTN=0):
//   - All outputs 0, FIFO empty, reply slot empty, state ST_IDLE.
//   - Mid-packet reset abandons the packet; no partial state is retained.
//  Packet formats:
//   - Sample: {HDR_ADS_DATA, ch1, ch2}.
//   - Reply: {HDR_ADS_REG or HDR_MPR_REG per i_REG_SRC, addr, data, 32'h0}.
//  Sample FIFO:
//   - Push on i_ADS_DATA_VALID when not full.
//   - Push while full: sample discarded, o_DROP_CNT+1, saturating at 8'hFF.
//   - Push and pop in the same cycle when full: both happen and nothing is dropped.
//   - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from the MSB compare.
//  Reply slot (one entry):
//   - i_REG_VALID loads the slot if empty.
//   - If the slot is occupied, the new reply is ignored; no counter is kept.
//  i_FLUSH:
//   - Empties the FIFO and does not touch the reply slot.
//   - A packet already presented stays valid until it is accepted.
//  FSM:
//   - ST_IDLE: if the reply slot is full, latch the reply into o_UART_DATA_TX and free the slot.
//     Otherwise, if the FIFO is not empty, latch the FIFO head and pop. Either way go to
//     ST_PRESENT. With neither source, stay.
//   - ST_PRESENT: o_UART_DATA_TX_VALID=1 and o_UART_DATA_TX held stable. Wait for i_READY=1,
//     then go to ST_ACCEPT.
//   - ST_ACCEPT: valid stays 1. When i_UART_DATA_TX_READY falls to 0, the packet is taken:
//     drop valid and go to ST_WAIT. If READY stays 1 (controller busy with RX), hold.
//   - ST_WAIT: valid=0. Wait for READY=1 (controller back in idle), then go to ST_IDLE.
//  Acceptance rule: a packet counts as consumed only on a READY 1->0 transition while valid.
//   A cycle with valid&ready high alone is not a transfer.
//  Latency: pending source -> valid high is 2 cycles (IDLE latch, PRESENT).
//  Packets never overlap, and data never changes while valid is high.
//  Simultaneous events in one cycle: reply wins over sample. A FIFO push and a pop may coincide.
//   If FLUSH and a push coincide, the flush wins and the sample is discarded without a drop count.
// TESTING
//  - Reset: hold i_RSTN=0 mid-ST_ACCEPT -> valid=0, o_DROP_CNT=0, FIFO empty, ST_IDLE after release.
//  - Sample: push 48'h123456_ABCDEF, model READY 1->0 after 3 cycles
//    -> o_UART_DATA_TX=56'hAA123456ABCDEF valid within 2 cycles, dropped on the fall.
//  - Priority: same cycle push sample plus reply ADS addr 8'h01 data 8'h55
//    -> first packet 56'h61015500000000, then the sample packet.
//  - Overflow: READY=0, push 6 samples with FIFO_DEPTH=4 -> o_FIFO_FULL=1, o_DROP_CNT=1
//    (one in the output register); later packets come out in push order.
//  - Flush: 3 samples queued, one presented, pulse i_FLUSH
//    -> presented packet completes, no further packets, o_FIFO_FULL=0.
//  - RX contention: hold READY=1 for 20 cycles with valid high, no fall
//    -> packet held unchanged, no pop, no duplicate on the later fall.

Source files
------------

// File: rtl/uart_packet_packer.sv
// uart_packet_packer
//   Frames ADS sample pairs and ADS/MPR register-read replies into 56-bit
//   packets (header byte in [55:48]) for the UART TX controller. Samples are
//   buffered in a small FIFO so the sensor side never waits on the UART.
//   A pending register reply always goes out ahead of queued samples.
//
// Ports
//   i_CLK, i_RSTN           clock, asynchronous active-low reset
//   i_ADS_DATA(_VALID)      {ch1, ch2} sample pair and its push strobe
//   i_REG_ADDR/DATA/SRC     register reply (SRC 0 = ADS, 1 = MPR)
//   i_REG_VALID             reply strobe
//   i_FLUSH                 discard queued samples
//   i_UART_DATA_TX_READY    controller ready; its 1->0 fall while valid
//                           is what consumes a packet
//   o_UART_DATA_TX(_VALID)  packet and its valid flag
//   o_FIFO_FULL             sample FIFO holds FIFO_DEPTH entries
//   o_DROP_CNT              saturating count of samples lost to a full FIFO
module uart_packet_packer #(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  HDR_ADS_DATA = 8'hAA,
  parameter logic [7:0]  HDR_ADS_REG  = 8'h61,
  parameter logic [7:0]  HDR_MPR_REG  = 8'h6D
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [47:0] i_ADS_DATA,
  input  logic        i_ADS_DATA_VALID,
  input  logic [7:0]  i_REG_ADDR,
  input  logic [7:0]  i_REG_DATA,
  input  logic        i_REG_SRC,
  input  logic        i_REG_VALID,
  input  logic        i_FLUSH,
  input  logic        i_UART_DATA_TX_READY,
  output logic [55:0] o_UART_DATA_TX,
  output logic        o_UART_DATA_TX_VALID,
  output logic        o_FIFO_FULL,
  output logic [7:0]  o_DROP_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_ACCEPT, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [47:0]   fifoMem_q [FIFO_DEPTH];
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic [7:0]    dropCnt_q, dropCnt_d;
  logic          slotFull_q, slotFull_d;
  logic [55:0]   slotData_q, slotData_d;
  logic [55:0]   dataTx_q, dataTx_d;

  logic          fifoEmpty;
  logic          fifoFull;
  logic          pop;
  logic          push;
  logic          takeReply;

  // Extra pointer MSB separates "full" (MSBs differ) from "empty" (equal).
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // Packet FSM. A packet is only consumed on READY falling while valid, so
  // a long READY-high stretch (controller busy on RX) just holds the packet.
  // A flush in the same cycle as an IDLE pick blocks the sample pop, so
  // nothing from a discarded FIFO ever reaches the output.
  always_comb begin
    state_d   = state_q;
    dataTx_d  = dataTx_q;
    pop       = 1'b0;
    takeReply = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slotFull_q) begin
          dataTx_d  = slotData_q;
          takeReply = 1'b1;
          state_d   = ST_PRESENT;
        end else if (!fifoEmpty && !i_FLUSH) begin
          dataTx_d = {HDR_ADS_DATA, fifoMem_q[rdPtr_q[AW-1:0]]};
          pop      = 1'b1;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: if (i_UART_DATA_TX_READY)  state_d = ST_ACCEPT;
      ST_ACCEPT:  if (!i_UART_DATA_TX_READY) state_d = ST_WAIT;
      ST_WAIT:    if (i_UART_DATA_TX_READY)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers and drop counter. A pop in the same cycle frees a slot,
  // so a push into a full FIFO is accepted then; a flush discards the push
  // without counting it as a drop.
  always_comb begin
    push      = 1'b0;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q + (AW+1)'(pop);
    dropCnt_d = dropCnt_q;
    if (i_FLUSH) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else if (i_ADS_DATA_VALID) begin
      if (!fifoFull || pop) begin
        push    = 1'b1;
        wrPtr_d = wrPtr_q + (AW+1)'(1);
      end else if (dropCnt_q != 8'hFF) begin
        dropCnt_d = dropCnt_q + 8'd1;
      end
    end
  end

  // Single reply slot: a reply arriving while it is occupied is lost.
  always_comb begin
    slotFull_d = slotFull_q;
    slotData_d = slotData_q;
    if (takeReply) slotFull_d = 1'b0;
    if (i_REG_VALID && !slotFull_q) begin
      slotFull_d = 1'b1;
      slotData_d = {(i_REG_SRC ? HDR_MPR_REG : HDR_ADS_REG),
                    i_REG_ADDR, i_REG_DATA, 32'h0};
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q    <= ST_IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      dropCnt_q  <= '0;
      slotFull_q <= 1'b0;
      slotData_q <= '0;
      dataTx_q   <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      dropCnt_q  <= dropCnt_d;
      slotFull_q <= slotFull_d;
      slotData_q <= slotData_d;
      dataTx_q   <= dataTx_d;
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge i_CLK) begin
    if (push) fifoMem_q[wrPtr_q[AW-1:0]] <= i_ADS_DATA;
  end

  assign o_UART_DATA_TX       = dataTx_q;
  assign o_UART_DATA_TX_VALID = (state_q == ST_PRESENT) || (state_q == ST_ACCEPT);
  assign o_FIFO_FULL          = fifoFull;
  assign o_DROP_CNT           = dropCnt_q;

endmodule

// File: tb/tb_uart_packet_packer.sv
// tb_uart_packet_packer
//   Drives uart_packet_packer with directed scenarios and random traffic.
//   A queue-based reference model follows the sample FIFO, the reply slot
//   and the READY handshake phase; a negedge process compares every output
//   against it, and directed scenarios also check literal expected values.
module tb_uart_packet_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic [47:0] adsData;
  logic        adsValid;
  logic [7:0]  regAddr;
  logic [7:0]  regData;
  logic        regSrc;
  logic        regValid;
  logic        flush;
  logic        ready;
  logic [55:0] txData;
  logic        txValid;
  logic        fifoFull;
  logic [7:0]  dropCnt;

  int tests = 0;
  int fails = 0;

  uart_packet_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .i_CLK                (clk),
    .i_RSTN               (rstN),
    .i_ADS_DATA           (adsData),
    .i_ADS_DATA_VALID     (adsValid),
    .i_REG_ADDR           (regAddr),
    .i_REG_DATA           (regData),
    .i_REG_SRC            (regSrc),
    .i_REG_VALID          (regValid),
    .i_FLUSH              (flush),
    .i_UART_DATA_TX_READY (ready),
    .o_UART_DATA_TX       (txData),
    .o_UART_DATA_TX_VALID (txValid),
    .o_FIFO_FULL          (fifoFull),
    .o_DROP_CNT           (dropCnt)
  );

  always #5 clk = ~clk;

  // Reference model: queue of samples, one reply slot, the packet on show,
  // and where the READY handshake stands (shown / READY seen / awaiting READY).
  logic [47:0] mQueue[$];
  bit          mSlotV     = 0;
  logic [55:0] mSlot      = '0;
  bit          mShown     = 0;
  bit          mReadySeen = 0;
  bit          mAwaitRdy  = 0;
  logic [55:0] mData      = '0;
  logic [7:0]  mDrop      = '0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mQueue.delete();
      mSlotV = 0; mSlot = '0; mShown = 0; mReadySeen = 0; mAwaitRdy = 0;
      mData = '0; mDrop = '0;
    end else begin
      bit slotWasFull;
      bit wasFull;
      bit popped;
      slotWasFull = mSlotV;
      wasFull     = (mQueue.size() == DEPTH);
      popped      = 0;
      if (!mShown && !mAwaitRdy) begin
        if (mSlotV) begin
          mData = mSlot; mSlotV = 0; mShown = 1;
        end else if (!flush && mQueue.size() > 0) begin
          mData = {8'hAA, mQueue.pop_front()}; popped = 1; mShown = 1;
        end
      end else if (mShown && !mReadySeen) begin
        if (ready) mReadySeen = 1;
      end else if (mShown) begin
        if (!ready) begin mShown = 0; mReadySeen = 0; mAwaitRdy = 1; end
      end else begin
        if (ready) mAwaitRdy = 0;
      end
      if (flush) mQueue.delete();
      else if (adsValid) begin
        if (!wasFull || popped) mQueue.push_back(adsData);
        else if (mDrop != 8'hFF) mDrop = mDrop + 8'd1;
      end
      if (regValid && !slotWasFull) begin
        mSlotV = 1;
        mSlot  = {(regSrc ? 8'h6D : 8'h61), regAddr, regData, 32'h0};
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    checkOutput("model valid", 64'(txValid), 64'(mShown));
    checkOutput("model full", 64'(fifoFull), 64'(mQueue.size() == DEPTH));
    checkOutput("model drop", 64'(dropCnt), 64'(mDrop));
    if (mShown) checkOutput("model data", 64'(txData), 64'(mData));
  end

  // Drives one cycle of inputs, held across exactly one rising edge.
  task automatic applyStimulus(input logic av, input logic [47:0] ad,
                               input logic rv, input logic rs,
                               input logic [7:0] ra, input logic [7:0] rd,
                               input logic fl, input logic rdy);
    adsValid = av; adsData = ad;
    regValid = rv; regSrc = rs; regAddr = ra; regData = rd;
    flush = fl; ready = rdy;
    @(negedge clk); #1;
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, 48'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, rdy);
  endtask

  task automatic pushSample(input logic [47:0] d, input logic rdy);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, rdy);
  endtask

  // READY high, then falling (packet consumed), then high again (back idle).
  task automatic handshake();
    idleCycle(1'b1);
    idleCycle(1'b0);
    idleCycle(1'b1);
  endtask

  initial begin
    rstN = 1'b0;
    adsValid = 0; adsData = '0; regValid = 0; regSrc = 0;
    regAddr = '0; regData = '0; flush = 0; ready = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset valid", 64'(txValid), 64'd0);
    checkOutput("reset data", 64'(txData), 64'd0);
    checkOutput("reset full", 64'(fifoFull), 64'd0);
    checkOutput("reset drop", 64'(dropCnt), 64'd0);
    rstN = 1'b1;
    idleCycle(1'b0);

    // Single sample, READY held high 3 cycles then dropped.
    pushSample(48'h123456_ABCDEF, 1'b0);
    idleCycle(1'b0);
    checkOutput("sample valid", 64'(txValid), 64'd1);
    checkOutput("sample data", 64'(txData), 64'hAA123456ABCDEF);
    repeat (3) idleCycle(1'b1);
    checkOutput("sample held", 64'(txValid), 64'd1);
    idleCycle(1'b0);
    checkOutput("sample taken", 64'(txValid), 64'd0);
    idleCycle(1'b1);

    // Reply and sample in the same cycle: reply first.
    applyStimulus(1'b1, 48'h0A0B0C_0D0E0F, 1'b1, 1'b0, 8'h01, 8'h55, 1'b0, 1'b1);
    idleCycle(1'b0);
    checkOutput("prio reply", 64'(txData), 64'h61015500000000);
    handshake();
    idleCycle(1'b0);
    checkOutput("prio sample", 64'(txData), 64'hAA0A0B0C0D0E0F);
    checkOutput("prio valid", 64'(txValid), 64'd1);
    handshake();

    // Overflow: six pushes with READY low, one shown, four queued, one lost.
    for (int i = 0; i < 6; i++) pushSample(48'hC00000000000 + 48'(i), 1'b0);
    checkOutput("ovf full", 64'(fifoFull), 64'd1);
    checkOutput("ovf drop", 64'(dropCnt), 64'd1);
    checkOutput("ovf first", 64'(txData), 64'hAAC00000000000);
    for (int i = 1; i < 5; i++) begin
      handshake();
      idleCycle(1'b0);
      checkOutput("ovf order", 64'(txData), 64'hAAC00000000000 + 64'(i));
    end
    handshake();

    // Flush with one packet shown and a full FIFO behind it.
    for (int i = 0; i < 5; i++) pushSample(48'hF00000000000 + 48'(i), 1'b0);
    checkOutput("flush pre full", 64'(fifoFull), 64'd1);
    applyStimulus(1'b0, 48'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b1, 1'b0);
    checkOutput("flush full", 64'(fifoFull), 64'd0);
    checkOutput("flush kept", 64'(txData), 64'hAAF00000000000);
    handshake();
    repeat (4) idleCycle(1'b0);
    checkOutput("flush empty", 64'(txValid), 64'd0);

    // RX contention: READY high for 20 cycles, no duplicate after the fall.
    pushSample(48'h777777_888888, 1'b0);
    idleCycle(1'b1);
    for (int i = 0; i < 20; i++) begin
      idleCycle(1'b1);
      checkOutput("rx hold", 64'(txData), 64'hAA777777888888);
    end
    idleCycle(1'b0);
    checkOutput("rx taken", 64'(txValid), 64'd0);
    repeat (5) idleCycle(1'b1);
    checkOutput("rx no dup", 64'(txValid), 64'd0);

    // Reset while a packet sits in the accept phase (drop count is 1 here).
    pushSample(48'h111111_222222, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("rst valid", 64'(txValid), 64'd0);
    checkOutput("rst drop", 64'(dropCnt), 64'd0);
    checkOutput("rst data", 64'(txData), 64'd0);
    idleCycle(1'b1);
    rstN = 1'b1;
    repeat (3) idleCycle(1'b1);
    checkOutput("rst idle", 64'(txValid), 64'd0);
    checkOutput("rst fifo", 64'(fifoFull), 64'd0);

    // Drop counter saturation.
    for (int i = 0; i < 270; i++) pushSample(48'(i), 1'b0);
    checkOutput("sat drop", 64'(dropCnt), 64'hFF);
    rstN = 1'b0;
    idleCycle(1'b0);
    rstN = 1'b1;
    idleCycle(1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 99) < 40, 48'({$urandom(), $urandom()}),
                    $urandom_range(0, 99) < 10, 1'($urandom_range(0, 1)),
                    8'($urandom()), 8'($urandom()),
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 50);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
